// File: rtl/adc_serial_deser.sv
// Serial-to-parallel ADC capture: framed shift register, channel tagging, valid/ready output.
// Latency: word appears 1 cycle after the final enable; frame_err pulses 1 cycle after a mid-frame frame_start.
// Backpressure: a word completing while the output is full is dropped and sets sticky overrun. Optional parity: ADC_PARITY_EN.
module adc_serial_deser #(
    parameter int WIDTH     = 10,
    parameter int MSB_FIRST = 1,
    parameter int NUM_CH    = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             sdata,
    input  logic             clr_err,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]  out_chan,
    output logic             out_valid,
    output logic             out_perr,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

`ifdef ADC_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt, w_sh_shift, w_word;
    logic             w_last, w_restart, w_load;
    logic [WIDTH-1:0] r_data;
    logic [CH_W-1:0]  r_chan;
    logic             r_valid, r_overrun, r_frame_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_restart   = 1'b0;
        w_sh_shift  = (MSB_FIRST != 0) ? {r_sh[WIDTH-2:0], sdata} : {sdata, r_sh[WIDTH-1:1]};
        w_last      = (r_state == S_SHIFT) && enable && (r_cnt == CNT_W'(FRAME_BITS - 1));
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sh_nxt    = '0;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    // A frame_start coinciding with the final bit starts the next frame cleanly
                    w_state_nxt = frame_start ? S_SHIFT : S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sh_nxt    = frame_start ? '0 : r_sh;
                end else if (frame_start) begin
                    w_restart = 1'b1;
                    w_cnt_nxt = '0;
                    w_sh_nxt  = '0;
                end else if (enable) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_sh_nxt  = w_sh_shift;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ADC_PARITY_EN
    // Final bit is the parity bit; the data is already complete in r_sh
    logic w_perr, r_perr;
    assign w_word = r_sh;
    assign w_perr = ^{r_sh, sdata};
`else
    assign w_word = w_sh_shift;
`endif

    assign w_load = w_last && (!r_valid || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_chan      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_restart;
            if (w_load) begin
                r_data  <= w_word;
                r_chan  <= r_chan_slot();
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_last && !w_load)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
        end
    end

    // Channel slot counter advances on every completed frame, loaded or dropped
    logic [CH_W-1:0] r_slot;
    function automatic logic [CH_W-1:0] r_chan_slot();
        return r_slot;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_slot <= '0;
        else if (w_last)
            r_slot <= (r_slot == CH_W'(NUM_CH - 1)) ? '0 : r_slot + CH_W'(1);
    end

`ifdef ADC_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_perr <= 1'b0;
        else if (w_load)
            r_perr <= w_perr;
    end
    assign out_perr = r_perr;
`else
    assign out_perr = 1'b0;
`endif

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;
    assign busy      = (r_state == S_SHIFT);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
